alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the next-generation MIPS datapath. It extends the single-cycle integer ALU with unsigned compare, XOR/NOR, and iterative signed/unsigned multiply and divide into HI/LO registers, behind a valid/ready handshake. It sits in the execute stage. The controller stalls on `in_ready` low while a multiply or divide is in flight.

---
 rtl/alu_mc.sv | 179 +++++++++++++++++
 tb/tb_alu_mc.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
`timescale 1ns/1ps
// alu_mc: execute-stage ALU. Logic/compare/add ops complete in one cycle; multiply
// and divide iterate one bit per cycle into HI/LO behind a valid/ready handshake.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   addend_reg, a_raw_reg;
  logic               neg_res_reg, neg_rem_reg, b_zero_reg, is_div_reg;
  logic [WIDTH-1:0]   result_reg, hi_reg, lo_reg;
  logic               zero_reg, out_valid_reg, dbz_reg;

  logic             accept, is_mul, is_div, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b, simple_res;

  assign accept = in_valid && in_ready;
  assign is_mul = (op[3:1] == 3'b110);
  assign is_div = (op[3:1] == 3'b111);
  // op[0] selects the signed variant of both MULT and DIV
  assign sign_a = op[0] && src_a[WIDTH-1];
  assign sign_b = op[0] && src_b[WIDTH-1];
  assign mag_a  = sign_a ? -src_a : src_a;
  assign mag_b  = sign_b ? -src_b : src_b;

  always_comb begin
    simple_res = '0;
    case (op)
      4'b0000: simple_res = src_a & src_b;
      4'b0001: simple_res = src_a | src_b;
      4'b0010: simple_res = src_a + src_b;
      4'b0110: simple_res = src_a - src_b;
      4'b0111: simple_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b1000: simple_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      4'b1001: simple_res = src_a ^ src_b;
      4'b1010: simple_res = ~(src_a | src_b);
      default: simple_res = '0;
    endcase
  end

  // One shift-add step: upper half accumulates, whole product shifts right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} +
                   (prod_reg[0] ? {1'b0, addend_reg} : {(WIDTH+1){1'b0}});

  // One restoring step: {remainder, next dividend bit} trial-subtracts the divisor.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff, div_rem;
  logic             div_ok;
  assign div_shift = prod_reg[2*WIDTH-1:WIDTH-1];
  assign div_ok    = (div_shift >= {1'b0, addend_reg});
  assign div_diff  = div_shift[WIDTH-1:0] - addend_reg;
  assign div_rem   = div_ok ? div_diff : div_shift[WIDTH-1:0];

  logic [2*WIDTH-1:0] mul_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  always_comb begin
    mul_fix = neg_res_reg ? -prod_reg : prod_reg;
    fix_hi  = mul_fix[2*WIDTH-1:WIDTH];
    fix_lo  = mul_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (b_zero_reg) begin
        fix_lo = '1;
        fix_hi = a_raw_reg;
      end else begin
        fix_lo = neg_res_reg ? -prod_reg[WIDTH-1:0] : prod_reg[WIDTH-1:0];
        fix_hi = neg_rem_reg ? -prod_reg[2*WIDTH-1:WIDTH] : prod_reg[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept && is_mul)      state_next = S_MUL;
        else if (accept && is_div) state_next = S_DIV;
      end
      S_MUL, S_DIV: if (cnt_reg == CW'(WIDTH-1)) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      prod_reg      <= '0;
      addend_reg    <= '0;
      a_raw_reg     <= '0;
      neg_res_reg   <= 1'b0;
      neg_rem_reg   <= 1'b0;
      b_zero_reg    <= 1'b0;
      is_div_reg    <= 1'b0;
      result_reg    <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      zero_reg      <= 1'b1;
      out_valid_reg <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            dbz_reg <= 1'b0;
            if (is_mul || is_div) begin
              cnt_reg     <= '0;
              prod_reg    <= {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
              addend_reg  <= is_mul ? mag_a : mag_b;
              a_raw_reg   <= src_a;
              neg_res_reg <= sign_a ^ sign_b;
              neg_rem_reg <= sign_a;
              b_zero_reg  <= (src_b == '0);
              is_div_reg  <= is_div;
            end else begin
              result_reg    <= simple_res;
              zero_reg      <= (simple_res == '0);
              out_valid_reg <= 1'b1;
            end
          end
        end
        S_MUL: begin
          prod_reg <= {mul_sum, prod_reg[WIDTH-1:1]};
          cnt_reg  <= cnt_reg + 1'b1;
        end
        S_DIV: begin
          prod_reg <= {div_rem, prod_reg[WIDTH-2:0], div_ok};
          cnt_reg  <= cnt_reg + 1'b1;
        end
        S_FIX: begin
          hi_reg     <= fix_hi;
          lo_reg     <= fix_lo;
          result_reg <= fix_lo;
          zero_reg   <= (fix_lo == '0);
          dbz_reg    <= is_div_reg && b_zero_reg;
        end
        S_DONE:  out_valid_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  assign out_valid   = out_valid_reg;
  assign result      = result_reg;
  assign zero_flag   = zero_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;
  assign div_by_zero = dbz_reg;
endmodule

// File: tb/tb_alu_mc.sv
`timescale 1ns/1ps
// tb_alu_mc: drives a 32-bit and an 8-bit alu_mc with directed and random ops and
// checks every completion against an arithmetic reference model.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  op = 4'b0000;
  logic [63:0] src_a = '0, src_b = '0;
  bit          sel8 = 1'b0;
  int          cur_w = 32, cur_s = 0;
  int          total = 0, bad = 0;
  logic [63:0] mhi [2];
  logic [63:0] mlo [2];

  logic        iv32, rdy32, ov32, zf32, dz32;
  logic [31:0] res32, hi32, lo32;
  logic        iv8, rdy8, ov8, zf8, dz8;
  logic [7:0]  res8, hi8, lo8;
  logic        rdy_o, ov_o;
  logic [63:0] res_o, zf_o, hi_o, lo_o, dz_o;

  assign iv32  = in_valid & ~sel8;
  assign iv8   = in_valid & sel8;
  assign rdy_o = sel8 ? rdy8 : rdy32;
  assign ov_o  = sel8 ? ov8 : ov32;
  assign res_o = sel8 ? {56'd0, res8} : {32'd0, res32};
  assign hi_o  = sel8 ? {56'd0, hi8} : {32'd0, hi32};
  assign lo_o  = sel8 ? {56'd0, lo8} : {32'd0, lo32};
  assign zf_o  = {63'd0, (sel8 ? zf8 : zf32)};
  assign dz_o  = {63'd0, (sel8 ? dz8 : dz32)};

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .op(op),
    .src_a(src_a[31:0]), .src_b(src_b[31:0]), .out_valid(ov32), .result(res32),
    .zero_flag(zf32), .hi(hi32), .lo(lo32), .div_by_zero(dz32)
  );
  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .op(op),
    .src_a(src_a[7:0]), .src_b(src_b[7:0]), .out_valid(ov8), .result(res8),
    .zero_flag(zf8), .hi(hi8), .lo(lo8), .div_by_zero(dz8)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (w=%0d): got=%h expected=%h", tag, cur_w, got, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: plain integer arithmetic on sign-extended operands.
  task automatic model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output bit dz, output bit multi);
    logic [63:0] mask, msb, p;
    longint sa, sb, q, rm;
    mask = wmask(cur_w);
    msb  = 64'd1 << (cur_w - 1);
    sa = a[cur_w-1] ? longint'(a) - longint'(64'd1 << cur_w) : longint'(a);
    sb = b[cur_w-1] ? longint'(b) - longint'(64'd1 << cur_w) : longint'(b);
    r = '0; dz = 1'b0; multi = 1'b0;
    case (o)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = (a + b) & mask;
      4'b0110: r = (a - b) & mask;
      4'b0111: r = (sa < sb) ? 64'd1 : 64'd0;
      4'b1000: r = (a < b) ? 64'd1 : 64'd0;
      4'b1001: r = a ^ b;
      4'b1010: r = ~(a | b) & mask;
      4'b1100, 4'b1101: begin
        multi = 1'b1;
        p = (o == 4'b1100) ? a * b : 64'(sa * sb);
        mlo[cur_s] = p & mask;
        mhi[cur_s] = (p >> cur_w) & mask;
      end
      4'b1110, 4'b1111: begin
        multi = 1'b1;
        if (b == 64'd0) begin
          dz = 1'b1;
          mlo[cur_s] = mask;
          mhi[cur_s] = a;
        end else if (o == 4'b1110) begin
          mlo[cur_s] = a / b;
          mhi[cur_s] = a % b;
        end else if (a == msb && b == mask) begin
          mlo[cur_s] = msb;
          mhi[cur_s] = 64'd0;
        end else begin
          q  = sa / sb;
          rm = sa % sb;
          mlo[cur_s] = 64'(q) & mask;
          mhi[cur_s] = 64'(rm) & mask;
        end
      end
      default: r = '0;
    endcase
    if (multi) r = mlo[cur_s];
  endtask

  task automatic do_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] er;
    bit edz, emulti, busy_ok;
    int n;
    model(o, a, b, er, edz, emulti);
    @(negedge clk);
    chk("ready_before", {63'd0, rdy_o}, 64'd1);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (n < 300) begin
      @(negedge clk);
      if (ov_o) break;
      if (rdy_o) busy_ok = 1'b0;
      @(posedge clk);
      n++;
    end
    chk("latency", 64'(n), emulti ? 64'(cur_w + 2) : 64'd0);
    if (emulti) chk("busy_not_ready", {63'd0, busy_ok}, 64'd1);
    chk("result", res_o, er);
    chk("zero_flag", zf_o, (er == 64'd0) ? 64'd1 : 64'd0);
    chk("hi", hi_o, mhi[cur_s]);
    chk("lo", lo_o, mlo[cur_s]);
    chk("div_by_zero", dz_o, {63'd0, edz});
    chk("ready_at_done", {63'd0, rdy_o}, 64'd1);
    $display("txn w=%0d op=%b a=%h b=%h result=%h hi=%h lo=%h dbz=%0d lat=%0d",
             cur_w, o, a, b, res_o, hi_o, lo_o, dz_o[0], n);
    @(negedge clk);
    chk("single_pulse", {63'd0, ov_o}, 64'd0);
  endtask

  // Five simple ops on consecutive edges; each result is due the cycle after its accept.
  task automatic b2b();
    logic [3:0]  ol [5];
    logic [63:0] al [5];
    logic [63:0] bl [5];
    logic [63:0] el [5];
    logic [63:0] mask, msb;
    bit dz, mu;
    mask = wmask(cur_w);
    msb  = 64'd1 << (cur_w - 1);
    ol[0] = 4'b0010; al[0] = msb - 64'd1; bl[0] = 64'd1;
    ol[1] = 4'b0110; al[1] = 64'd5;       bl[1] = 64'd5;
    ol[2] = 4'b0111; al[2] = mask;        bl[2] = 64'd1;
    ol[3] = 4'b1000; al[3] = mask;        bl[3] = 64'd1;
    ol[4] = 4'b1010; al[4] = 64'd0;       bl[4] = 64'd0;
    for (int i = 0; i < 5; i++) model(ol[i], al[i], bl[i], el[i], dz, mu);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("b2b_valid", {63'd0, ov_o}, 64'd1);
        chk("b2b_result", res_o, el[k-1]);
        chk("b2b_zero", zf_o, (el[k-1] == 64'd0) ? 64'd1 : 64'd0);
        $display("txn w=%0d op=%b a=%h b=%h result=%h", cur_w, ol[k-1], al[k-1], bl[k-1], res_o);
      end
      if (k < 5) begin
        op = ol[k]; src_a = al[k]; src_b = bl[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  // ADD held on in_valid while a DIV is busy must be taken exactly at E+WIDTH+3.
  task automatic handshake();
    logic [63:0] ar, dr, a1, dhi, dlo;
    bit dz, mu, rdy;
    int m, acc, dlat;
    a1 = 64'($urandom) & wmask(cur_w);
    model(4'b1111, a1, 64'd3, dr, dz, mu);
    dhi = mhi[cur_s]; dlo = mlo[cur_s];
    model(4'b0010, 64'd5, 64'd9, ar, dz, mu);
    @(negedge clk);
    op = 4'b1111; src_a = a1; src_b = 64'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 op = 4'b0010; src_a = 64'd5; src_b = 64'd9;
    m = 0; acc = -1; dlat = -1;
    while (acc < 0 && m < 300) begin
      @(negedge clk);
      rdy = rdy_o;
      if (ov_o) begin
        dlat = m;
        chk("hs_div_lo", lo_o, dlo);
        chk("hs_div_hi", hi_o, dhi);
      end
      @(posedge clk);
      m++;
      if (rdy) acc = m;
    end
    #1 in_valid = 1'b0;
    chk("hs_div_latency", 64'(dlat), 64'(cur_w + 2));
    chk("hs_accept_edge", 64'(acc), 64'(cur_w + 3));
    @(negedge clk);
    chk("hs_add_valid", {63'd0, ov_o}, 64'd1);
    chk("hs_add_result", res_o, ar);
    chk("hs_add_hi_kept", hi_o, dhi);
    $display("txn w=%0d handshake div a=%h b=3 then add accepted at E+%0d result=%h", cur_w, a1, acc, res_o);
  endtask

  task automatic reset_mid_op();
    int pulses;
    @(negedge clk);
    op = 4'b1101; src_a = 64'd123; src_b = 64'd45; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_result", res_o, 64'd0);
    chk("rst_zero", zf_o, 64'd1);
    chk("rst_hi", hi_o, 64'd0);
    chk("rst_lo", lo_o, 64'd0);
    chk("rst_valid", {63'd0, ov_o}, 64'd0);
    chk("rst_dbz", dz_o, 64'd0);
    chk("rst_ready", {63'd0, rdy_o}, 64'd1);
    mhi[0] = '0; mhi[1] = '0; mlo[0] = '0; mlo[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (cur_w + 6) begin
      @(negedge clk);
      if (ov_o) pulses++;
    end
    chk("rst_no_completion", 64'(pulses), 64'd0);
    $display("txn w=%0d reset during MULT, outputs cleared", cur_w);
    do_op(4'b0010, 64'd20, 64'd22);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return wmask(cur_w);
      3: return 64'd1 << (cur_w - 1);
      default: return 64'($urandom) & wmask(cur_w);
    endcase
  endfunction

  initial begin
    logic [3:0] ops [14];
    logic [63:0] mk, ms;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001,
            4'b1010, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0011, 4'b1011};
    mhi[0] = '0; mhi[1] = '0; mlo[0] = '0; mlo[1] = '0;
    repeat (3) @(negedge clk);
    chk("por_result", res_o, 64'd0);
    chk("por_zero", zf_o, 64'd1);
    chk("por_valid", {63'd0, ov_o}, 64'd0);
    chk("por_ready", {63'd0, rdy_o}, 64'd1);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      sel8 = (s == 1);
      cur_s = s;
      cur_w = (s == 1) ? 8 : 32;
      mk = wmask(cur_w);
      ms = 64'd1 << (cur_w - 1);
      b2b();
      do_op(4'b1101, mk - 64'd2, 64'd7);
      do_op(4'b1100, mk, mk);
      do_op(4'b1111, mk - 64'd6, 64'd2);
      do_op(4'b1110, 64'd100, 64'd0);
      do_op(4'b1111, ms, mk);
      do_op(4'b1111, 64'd7, mk - 64'd1);
      do_op(4'b1111, mk - 64'd4, 64'd0);
      do_op(4'b0011, 64'd5, 64'd6);
      handshake();
      reset_mid_op();
      for (int i = 0; i < 150; i++) begin
        do_op(ops[$urandom_range(0, 13)], pick(), pick());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
